instr_fetch_unit: RTL and testbench

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

---
 rtl/agm_pkg.sv | 9 +
 rtl/instr_queue.sv | 43 ++++
 rtl/instr_fetch_unit.sv | 106 ++++++++++
 tb/tb_instr_fetch_unit.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/agm_pkg.sv
// agm_pkg: fetch FSM states and default fetch-unit parameters
package agm_pkg;
  typedef enum logic [1:0] {IDLE, FETCH, FULL, FLUSH} fetch_state_e;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 8;
  localparam int DEF_INSTR_BYTES = 3;
  localparam int DEF_QUEUE_DEPTH = 4;
  localparam int DEF_RESET_PC = 0;
endpackage

// File: rtl/instr_queue.sv
// instr_queue: power-of-two FIFO with flush, simultaneous push/pop and occupancy count
module instr_queue #(
  parameter int W = 8,
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    push,
  input  logic [W-1:0]            push_data,
  input  logic                    pop,
  output logic [W-1:0]            pop_data,
  output logic [$clog2(DEPTH):0]  count
);
  localparam int PW = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [PW:0] count_q, count_d;
  logic do_push, do_pop;
  always_comb begin
    do_pop = pop && count_q != '0;
    do_push = push && (count_q != (PW+1)'(DEPTH) || do_pop);
    wr_d = flush ? '0 : wr_q + PW'(do_push);
    rd_d = flush ? '0 : rd_q + PW'(do_pop);
    count_d = flush ? '0 : count_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
      count_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      count_q <= count_d;
    end
  end
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_q] <= push_data;
  end
  assign pop_data = mem_q[rd_q];
  assign count = count_q;
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: byte-wide prefetcher assembling multi-byte instructions into a queue
module instr_fetch_unit
  import agm_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int INSTR_BYTES = DEF_INSTR_BYTES,
  parameter int QUEUE_DEPTH = DEF_QUEUE_DEPTH,
  parameter int RESET_PC = DEF_RESET_PC
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          fetch_en,
  output logic                          mem_rd_en,
  output logic [ADDR_W-1:0]             mem_addr,
  input  logic [DATA_W-1:0]             mem_data,
  input  logic                          branch_valid,
  input  logic [ADDR_W-1:0]             branch_target,
  output logic                          instr_valid,
  input  logic                          instr_ready,
  output logic [DATA_W*INSTR_BYTES-1:0] instr_word,
  output logic [ADDR_W-1:0]             instr_pc,
  output logic [$clog2(QUEUE_DEPTH):0]  queue_count
);
  localparam int IW = DATA_W*INSTR_BYTES;
  localparam int CW = $clog2(QUEUE_DEPTH)+1;
  localparam int BW = $clog2(INSTR_BYTES+1);
  localparam logic [ADDR_W-1:0] RST_PC = ADDR_W'(RESET_PC);
  localparam logic [BW-1:0] LAST_IDX = BW'(INSTR_BYTES-1);
  fetch_state_e state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d, fly_addr_q, fly_addr_d, asm_pc_q, asm_pc_d;
  logic [ADDR_W-1:0] assembled_pc, head_pc;
  logic [BW-1:0] issue_idx_q, issue_idx_d, fly_idx_q, fly_idx_d;
  logic [CW-1:0] rsv_q, rsv_d, count;
  logic [IW-1:0] asm_word_q, asm_word_d, assembled, head_word;
  logic fly_q, fly_d;
  logic room, boundary, issue, push, pop;
  always_comb begin
    boundary = issue_idx_q == '0;
    room = int'(count) + int'(rsv_q) < QUEUE_DEPTH;
    issue = !rst && !branch_valid && state_q == FETCH && (!boundary || (fetch_en && room));
    push = fly_q && fly_idx_q == LAST_IDX && !branch_valid;
    assembled = asm_word_q;
    if (fly_q) assembled[IW-DATA_W-int'(fly_idx_q)*DATA_W +: DATA_W] = mem_data;
    assembled_pc = (fly_q && fly_idx_q == '0) ? fly_addr_q : asm_pc_q;
    asm_word_d = branch_valid ? '0 : assembled;
    asm_pc_d = branch_valid ? '0 : assembled_pc;
    fly_d = issue;
    fly_idx_d = issue_idx_q;
    fly_addr_d = fetch_pc_q;
    issue_idx_d = branch_valid ? '0 : !issue ? issue_idx_q : issue_idx_q == LAST_IDX ? '0 : issue_idx_q + BW'(1);
    fetch_pc_d = branch_valid ? branch_target : fetch_pc_q + ADDR_W'(issue);
    rsv_d = branch_valid ? '0 : rsv_q + CW'(issue && boundary) - CW'(push);
    state_d = state_q;
    if (branch_valid) state_d = FLUSH;
    else begin
      unique case (state_q)
        IDLE:    state_d = fetch_en ? FETCH : IDLE;
        FETCH:   state_d = !boundary ? FETCH : !fetch_en ? IDLE : room ? FETCH : FULL;
        FULL:    state_d = room ? FETCH : FULL;
        FLUSH:   state_d = fetch_en ? FETCH : IDLE;
        default: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      fetch_pc_q <= RST_PC;
      issue_idx_q <= '0;
      rsv_q <= '0;
      fly_q <= 1'b0;
      fly_idx_q <= '0;
      fly_addr_q <= '0;
      asm_word_q <= '0;
      asm_pc_q <= '0;
    end else begin
      state_q <= state_d;
      fetch_pc_q <= fetch_pc_d;
      issue_idx_q <= issue_idx_d;
      rsv_q <= rsv_d;
      fly_q <= fly_d;
      fly_idx_q <= fly_idx_d;
      fly_addr_q <= fly_addr_d;
      asm_word_q <= asm_word_d;
      asm_pc_q <= asm_pc_d;
    end
  end
  instr_queue #(.W(IW+ADDR_W), .DEPTH(QUEUE_DEPTH)) u_queue (
    .clk(clk),
    .rst(rst),
    .flush(branch_valid),
    .push(push),
    .push_data({assembled, assembled_pc}),
    .pop(pop),
    .pop_data({head_word, head_pc}),
    .count(count)
  );
  assign pop = instr_valid && instr_ready;
  assign mem_rd_en = issue;
  assign mem_addr = rst ? RST_PC : fetch_pc_q;
  assign instr_valid = !rst && count != '0;
  assign instr_word = instr_valid ? head_word : '0;
  assign instr_pc = instr_valid ? head_pc : '0;
  assign queue_count = rst ? '0 : count;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed and randomized checks against an instruction-stream reference model
module tb_instr_fetch_unit;
  logic clk, rst, fetch_en, mem_rd_en, branch_valid, instr_valid, instr_ready;
  logic [7:0] mem_addr, mem_data, branch_target, instr_pc;
  logic [23:0] instr_word;
  logic [2:0] queue_count;
  logic [7:0] ram [256];
  logic [7:0] exp_pc, hold_pc;
  logic [23:0] hold_word;
  logic hold, rst_edge;
  int errors = 0, checks = 0, cyc = 0, pops = 0;

  instr_fetch_unit #(.DATA_W(8), .ADDR_W(8), .INSTR_BYTES(3), .QUEUE_DEPTH(4), .RESET_PC(0)) dut (
    .clk(clk), .rst(rst), .fetch_en(fetch_en), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
    .mem_data(mem_data), .branch_valid(branch_valid), .branch_target(branch_target),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_word(instr_word),
    .instr_pc(instr_pc), .queue_count(queue_count)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  always @(posedge clk) mem_data <= mem_rd_en ? ram[mem_addr] : 8'($urandom);
  always @(posedge clk) rst_edge = rst;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [23:0] model_word(input logic [7:0] pc);
    logic [23:0] w = '0;
    logic [7:0] a;
    for (int i = 0; i < 3; i++) begin
      a = pc + 8'(i);
      w = {w[15:0], ram[a]};
    end
    return w;
  endfunction

  always @(negedge clk) begin
    if (rst_edge) exp_pc = 8'h00;
    else if (!rst) begin
      check("count_max", 32'(queue_count <= 3'd4), 1);
      check("valid_vs_count", instr_valid, queue_count != 0);
      if (hold) begin
        check("hold_word", instr_word, hold_word);
        check("hold_pc", instr_pc, hold_pc);
      end
      if (instr_valid && instr_ready) begin
        check("pop_pc", instr_pc, exp_pc);
        check("pop_word", instr_word, model_word(exp_pc));
        exp_pc = exp_pc + 8'd3;
        pops++;
      end
      if (branch_valid) exp_pc = branch_target;
    end
    hold = !rst && instr_valid && !instr_ready && !branch_valid;
    hold_word = instr_word;
    hold_pc = instr_pc;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic go(input int n);
    step(n - cyc);
  endtask

  task automatic do_reset(input bit rnd);
    rst = 1; fetch_en = 0; instr_ready = 0; branch_valid = 0; branch_target = 0;
    if (rnd) for (int i = 0; i < 256; i++) ram[i] = 8'($urandom);
    step(2);
    @(negedge clk);
    check("rst_rd_en", mem_rd_en, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_valid", instr_valid, 0);
    check("rst_word", instr_word, 0);
    check("rst_pc", instr_pc, 0);
    check("rst_count", queue_count, 0);
    step(1);
    rst = 0;
    cyc = 0;
  endtask

  task automatic set_cold_ram();
    ram[0] = 8'h11; ram[1] = 8'h22; ram[2] = 8'h33;
    ram[3] = 8'h44; ram[4] = 8'h55; ram[5] = 8'h66;
  endtask

  initial begin
    rst = 1;
    hold = 0;
    for (int i = 0; i < 256; i++) ram[i] = 8'($urandom);
    set_cold_ram();
    ram[8'h40] = 8'hA1; ram[8'h41] = 8'hB2; ram[8'h42] = 8'hC3;
    do_reset(0);
    fetch_en = 1; instr_ready = 1;
    @(negedge clk); check("c0_rd_en", mem_rd_en, 0);
    go(1); @(negedge clk);
    check("c1_rd_en", mem_rd_en, 1);
    check("c1_addr", mem_addr, 0);
    go(4); @(negedge clk); check("c4_valid", instr_valid, 0);
    go(5); @(negedge clk);
    check("c5_valid", instr_valid, 1);
    check("c5_word", instr_word, 24'h112233);
    check("c5_pc", instr_pc, 0);
    go(8); @(negedge clk);
    check("c8_word", instr_word, 24'h445566);
    check("c8_pc", instr_pc, 3);
    go(9); instr_ready = 0;
    go(12); branch_valid = 1; branch_target = 8'h40;
    @(negedge clk);
    check("br_count_before", queue_count, 1);
    check("br_rd_en", mem_rd_en, 0);
    go(13); branch_valid = 0; instr_ready = 1;
    @(negedge clk);
    check("br_count_after", queue_count, 0);
    check("flush_rd_en", mem_rd_en, 0);
    go(14); @(negedge clk);
    check("br_rd_en_resume", mem_rd_en, 1);
    check("br_addr_resume", mem_addr, 8'h40);
    go(18); @(negedge clk);
    check("br_word", instr_word, 24'hA1B2C3);
    check("br_pc", instr_pc, 8'h40);
    go(19);
    branch_valid = 1; branch_target = 8'hFF;
    ram[8'hFF] = 8'h01; ram[0] = 8'h02; ram[1] = 8'h03;
    go(20); branch_valid = 0;
    go(25); @(negedge clk);
    check("wrap_valid", instr_valid, 1);
    check("wrap_word", instr_word, 24'h010203);
    check("wrap_pc", instr_pc, 8'hFF);

    do_reset(0);
    set_cold_ram();
    fetch_en = 1; instr_ready = 0;
    go(9); @(negedge clk);
    check("bp_head_word", instr_word, 24'h112233);
    go(10); instr_ready = 1;
    @(negedge clk); check("pp_count_before", queue_count, 2);
    go(11); instr_ready = 0;
    @(negedge clk);
    check("pp_count_after", queue_count, 2);
    check("pp_word", instr_word, 24'h445566);
    check("pp_pc", instr_pc, 3);
    for (int i = 0; i < 40 && queue_count != 3; i++) begin
      step(1);
      @(negedge clk);
    end
    check("reach_count3", queue_count, 3);
    #2 rst = 1;
    step(1);
    rst = 0; cyc = 0;
    @(negedge clk);
    check("mid_rst_rd_en", mem_rd_en, 0);
    check("mid_rst_addr", mem_addr, 0);
    check("mid_rst_valid", instr_valid, 0);
    check("mid_rst_word", instr_word, 0);
    check("mid_rst_pc", instr_pc, 0);
    check("mid_rst_count", queue_count, 0);
    go(1); @(negedge clk);
    check("refetch_rd_en", mem_rd_en, 1);
    check("refetch_addr", mem_addr, 0);
    go(30); @(negedge clk);
    check("full_count", queue_count, 4);
    for (int i = 0; i < 4; i++) begin
      step(1); @(negedge clk);
      check("full_rd_en", mem_rd_en, 0);
      check("full_word", instr_word, 24'h112233);
      check("full_pc", instr_pc, 0);
    end
    step(1);
    branch_valid = 1; branch_target = 8'h80; instr_ready = 1;
    @(negedge clk); check("brpop_rd_en", mem_rd_en, 0);
    step(1);
    branch_valid = 0; instr_ready = 0;
    @(negedge clk);
    check("brpop_count", queue_count, 0);
    check("brpop_valid", instr_valid, 0);

    do_reset(1);
    pops = 0;
    for (int i = 0; i < 3000; i++) begin
      fetch_en = ($urandom % 10) != 0;
      instr_ready = $urandom % 2;
      branch_valid = ($urandom % 25) == 0;
      branch_target = 8'($urandom);
      step(1);
    end
    branch_valid = 0;
    @(negedge clk);
    check("random_pops_seen", 32'(pops > 100), 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
